i2c_target: RTL

I2C target (slave) endpoint for the controller/bus-master block in the same design. It shares its clock. It watches `scl` and the resolved SDA level, detects START, STOP and repeated START, and matches a 7-bit address. Write bytes are delivered on a byte-wide valid strobe. Read bytes are requested from and loaded by the local side. It drives SDA open-drain only during ACK slots and read data bits.

---
 rtl/i2c_target_pkg.sv | 29 ++
 rtl/i2c_sync_edge.sv | 39 +++
 rtl/i2c_target.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_target_pkg.sv
// Shared types for the I2C target: FSM state encodings, controller command codes
// and the address compare helper.
package i2c_target_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_WR_DATA  = 3'd3,
    ST_WR_ACK   = 3'd4,
    ST_RD_DATA  = 3'd5,
    ST_RD_ACK   = 3'd6,
    ST_IGNORE   = 3'd7
  } state_t;

  // Controller command codes, kept here so both bus ends agree on them.
  typedef enum logic [2:0] {
    CMD_START   = 3'd0,
    CMD_WR      = 3'd1,
    CMD_RD      = 3'd2,
    CMD_STOP    = 3'd3,
    CMD_RESTART = 3'd4
  } cmd_t;

  function automatic logic addr_match(input logic [7:0] addr_byte, input logic [6:0] addr);
    return addr_byte[7:1] == addr;
  endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// 2-FF synchroniser with registered rise/fall strobes; level, rise and fall are aligned,
// 3 clk cycles after the input edge. No backpressure.
module i2c_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;
  logic r_rise;
  logic r_fall;

  // Idle bus level is high, so reset to 1 to avoid a spurious edge after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
      r_rise <= r_sync & ~r_prev;
      r_fall <= ~r_sync & r_prev;
    end
  end

  assign o_level = r_prev;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/i2c_target.sv
// I2C target endpoint: START/STOP detect, 7-bit address match, byte write strobe and read
// byte requests; SDA moves 1 clk after a detected SCL fall. No flow control, always ACKs writes.
module i2c_target
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h42
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  input  logic       sda_input_m,
  output logic       sda_output_s,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       rw,
  output logic       busy
);

  logic   w_scl;
  logic   w_scl_rise;
  logic   w_scl_fall;
  logic   w_sda;
  logic   w_sda_rise;
  logic   w_sda_fall;
  logic   w_start;
  logic   w_stop;
  logic   w_cond;

  state_t r_state;
  state_t w_state_nxt;
  logic [7:0] r_shift;
  logic [2:0] r_bit_cnt;
  logic       r_ninth;
  logic       r_match;
  logic       r_sda_low;
  logic [7:0] r_rx_data;
  logic       r_rx_valid;
  logic       r_tx_req;
  logic       r_rw;
  logic       r_busy;

  logic w_cnt_inc;
  logic w_cnt_clr;
  logic w_shift_in;
  logic w_shift_out;
  logic w_load_tx;
  logic w_rx_load;
  logic w_req;
  logic w_addr_cmp;
  logic w_addr_hit;
  logic w_sda_low_nxt;
  logic w_busy_nxt;

  i2c_sync_edge u_scl_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (scl),
    .o_level (w_scl),
    .o_rise  (w_scl_rise),
    .o_fall  (w_scl_fall)
  );

  i2c_sync_edge u_sda_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (sda_input_m),
    .o_level (w_sda),
    .o_rise  (w_sda_rise),
    .o_fall  (w_sda_fall)
  );

  assign w_start = w_sda_fall & w_scl;
  assign w_stop  = w_sda_rise & w_scl;
  assign w_cond  = w_start | w_stop;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_start) begin
      w_state_nxt = ST_ADDR;
    end else if (w_stop) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_ADDR:     if (w_scl_fall && r_ninth) w_state_nxt = r_match ? ST_ADDR_ACK : ST_IGNORE;
        ST_ADDR_ACK: if (w_scl_fall) w_state_nxt = r_rw ? ST_RD_DATA : ST_WR_DATA;
        ST_WR_DATA:  if (w_scl_fall && r_ninth) w_state_nxt = ST_WR_ACK;
        ST_WR_ACK:   if (w_scl_fall) w_state_nxt = ST_WR_DATA;
        ST_RD_DATA:  if (w_scl_fall && r_ninth) w_state_nxt = ST_RD_ACK;
        ST_RD_ACK: begin
          if (w_scl_rise && w_sda)  w_state_nxt = ST_IGNORE;
          else if (w_scl_fall)      w_state_nxt = ST_RD_DATA;
        end
        default:     w_state_nxt = r_state;
      endcase
    end
  end

  // A bus condition in the same cycle as an SCL edge suppresses every strobe.
  always_comb begin
    w_cnt_inc     = 1'b0;
    w_cnt_clr     = w_cond;
    w_shift_in    = 1'b0;
    w_shift_out   = 1'b0;
    w_load_tx     = 1'b0;
    w_rx_load     = 1'b0;
    w_req         = 1'b0;
    w_addr_cmp    = 1'b0;
    w_addr_hit    = 1'b0;
    w_sda_low_nxt = r_sda_low;
    w_busy_nxt    = r_busy;
    if (w_cond) begin
      w_sda_low_nxt = 1'b0;
      w_busy_nxt    = 1'b0;
    end else begin
      case (r_state)
        ST_ADDR: begin
          if (w_scl_rise) begin
            w_cnt_inc  = 1'b1;
            w_shift_in = 1'b1;
            w_addr_cmp = (r_bit_cnt == 3'd7);
          end
          if (w_scl_fall && r_ninth) begin
            w_addr_hit    = r_match;
            w_sda_low_nxt = r_match;
            w_busy_nxt    = r_match;
          end
        end
        ST_ADDR_ACK: begin
          if (w_scl_rise && r_rw) w_req = 1'b1;
          if (w_scl_fall) begin
            w_cnt_clr     = 1'b1;
            w_load_tx     = r_rw;
            w_sda_low_nxt = r_rw & ~tx_data[7];
          end
        end
        ST_WR_DATA: begin
          if (w_scl_rise) begin
            w_cnt_inc  = 1'b1;
            w_shift_in = 1'b1;
            w_rx_load  = (r_bit_cnt == 3'd7);
          end
          if (w_scl_fall && r_ninth) w_sda_low_nxt = 1'b1;
        end
        ST_WR_ACK: begin
          if (w_scl_fall) begin
            w_cnt_clr     = 1'b1;
            w_sda_low_nxt = 1'b0;
          end
        end
        ST_RD_DATA: begin
          if (w_scl_rise) w_cnt_inc = 1'b1;
          if (w_scl_fall) begin
            w_shift_out   = ~r_ninth;
            w_sda_low_nxt = ~r_ninth & ~r_shift[6];
          end
        end
        ST_RD_ACK: begin
          if (w_scl_rise) begin
            if (w_sda) begin
              w_sda_low_nxt = 1'b0;
              w_busy_nxt    = 1'b0;
            end else begin
              w_req = 1'b1;
            end
          end else if (w_scl_fall) begin
            w_cnt_clr     = 1'b1;
            w_load_tx     = 1'b1;
            w_sda_low_nxt = ~tx_data[7];
          end
        end
        default: w_sda_low_nxt = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_ninth    <= 1'b0;
      r_match    <= 1'b0;
      r_sda_low  <= 1'b0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_tx_req   <= 1'b0;
      r_rw       <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_sda_low  <= w_sda_low_nxt;
      r_busy     <= w_busy_nxt;
      r_rx_valid <= w_rx_load;
      r_tx_req   <= w_req;
      if (w_cnt_clr) begin
        r_bit_cnt <= '0;
        r_ninth   <= 1'b0;
      end else if (w_cnt_inc) begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) r_ninth <= 1'b1;
      end
      if (w_shift_in)       r_shift <= {r_shift[6:0], w_sda};
      else if (w_load_tx)   r_shift <= tx_data;
      else if (w_shift_out) r_shift <= {r_shift[6:0], 1'b0};
      if (w_rx_load)  r_rx_data <= {r_shift[6:0], w_sda};
      if (w_addr_cmp) r_match   <= addr_match({r_shift[6:0], w_sda}, TARGET_ADDR);
      if (w_addr_hit) r_rw      <= r_shift[0];
    end
  end

  assign sda_output_s = r_sda_low ? 1'b0 : 1'bz;
  assign rx_data      = r_rx_data;
  assign rx_valid     = r_rx_valid;
  assign tx_req       = r_tx_req;
  assign rw           = r_rw;
  assign busy         = r_busy;

endmodule
